// File: rtl/spi_sram_pkg.sv
// Shared constants for the SPI SRAM responder: opcodes, FSM states, address modes.
package spi_sram_pkg;

  localparam logic [7:0] OP_READ    = 8'h03;
  localparam logic [7:0] OP_WRITE   = 8'h02;
  localparam logic [7:0] OP_RDSR    = 8'h05;
  localparam logic [7:0] OP_WRSR    = 8'h01;
  localparam logic [7:0] STATUS_RST = 8'h40;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_CMD     = 4'd1,
    ST_ADDR_HI = 4'd2,
    ST_ADDR_LO = 4'd3,
    ST_READ    = 4'd4,
    ST_WRITE   = 4'd5,
    ST_RDSR    = 4'd6,
    ST_WRSR    = 4'd7,
    ST_IGNORE  = 4'd8
  } state_e;

  typedef enum logic [1:0] {
    MODE_BYTE = 2'b00,
    MODE_SEQ  = 2'b01,
    MODE_PAGE = 2'b10,
    MODE_RSVD = 2'b11
  } mode_e;

  // The reserved encoding behaves as sequential.
  function automatic mode_e decode_mode(input logic [1:0] bits);
    case (bits)
      2'b00:   decode_mode = MODE_BYTE;
      2'b10:   decode_mode = MODE_PAGE;
      default: decode_mode = MODE_SEQ;
    endcase
  endfunction

endpackage

// File: rtl/spi_sram_sync.sv
// Synchronizes SCK/CS into clk50 and delays SI by the same depth; emits edge strobes.
module spi_sram_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic sck_i,
  input  logic cs_i,
  input  logic si_i,
  output logic si_o,
  output logic sck_rise_o,
  output logic sck_fall_o,
  output logic cs_fall_o,
  output logic cs_rise_o
);

  logic [SYNC_STAGES-1:0] sck_q, sck_d, cs_q, cs_d, si_q, si_d;
  logic sck_prev_q, sck_prev_d, cs_prev_q, cs_prev_d;
  logic sck_s, cs_s;

  assign sck_s = sck_q[SYNC_STAGES-1];
  assign cs_s  = cs_q[SYNC_STAGES-1];

  always_comb begin
    sck_d      = {sck_q[SYNC_STAGES-2:0], sck_i};
    cs_d       = {cs_q[SYNC_STAGES-2:0], cs_i};
    si_d       = {si_q[SYNC_STAGES-2:0], si_i};
    sck_prev_d = sck_s;
    cs_prev_d  = cs_s;
  end

  // CS chain resets low, so a CS already low at reset release produces no fall strobe.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sck_q      <= {SYNC_STAGES{1'b0}};
      cs_q       <= {SYNC_STAGES{1'b0}};
      si_q       <= {SYNC_STAGES{1'b0}};
      sck_prev_q <= 1'b0;
      cs_prev_q  <= 1'b0;
    end else begin
      sck_q      <= sck_d;
      cs_q       <= cs_d;
      si_q       <= si_d;
      sck_prev_q <= sck_prev_d;
      cs_prev_q  <= cs_prev_d;
    end
  end

  assign si_o       = si_q[SYNC_STAGES-1];
  assign sck_rise_o = sck_s & ~sck_prev_q;
  assign sck_fall_o = ~sck_s & sck_prev_q;
  assign cs_fall_o  = ~cs_s & cs_prev_q;
  assign cs_rise_o  = cs_s & ~cs_prev_q;

endmodule

// File: rtl/spi_sram_responder.sv
// SPI mode-0 SRAM responder with a 2^ADDR_W byte array.
// Optional status register (RDSR/WRSR, byte/page/sequential modes) under SPI_SRAM_RESP_STATUS_EN.
module spi_sram_responder
  import spi_sram_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk50_i,
  input  logic rst_n_i,
  input  logic mem_clk_i,
  input  logic mem_cs_i,
  input  logic mem_si_i,
  output logic mem_so_o,
  output logic mem_so_oe_o
);

  typedef logic [ADDR_W-1:0] addr_t;
  localparam int DEPTH = 2 ** ADDR_W;

  logic       si_s, sck_rise_s, sck_fall_s, cs_fall_s, cs_rise_s;
  state_e     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_in_q, shift_in_d;
  logic [7:0] shift_out_q, shift_out_d;
  logic [7:0] addr_hi_q, addr_hi_d;
  addr_t      addr_q, addr_d;
  logic       is_write_q, is_write_d;
  logic       so_q, so_d, oe_q, oe_d;
  mode_e      mode_s;
  logic [7:0] status_s;
  logic [7:0] mem_q [DEPTH];
  logic       byte_done_s, mem_we_s;
  logic [7:0] byte_val_s;
  addr_t      addr_next_s, addr_load_s;

  spi_sram_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk_i      (clk50_i),
    .rst_n_i    (rst_n_i),
    .sck_i      (mem_clk_i),
    .cs_i       (mem_cs_i),
    .si_i       (mem_si_i),
    .si_o       (si_s),
    .sck_rise_o (sck_rise_s),
    .sck_fall_o (sck_fall_s),
    .cs_fall_o  (cs_fall_s),
    .cs_rise_o  (cs_rise_s)
  );

  function automatic addr_t advance(input addr_t a, input mode_e m);
    case (m)
      MODE_BYTE: advance = a;
      MODE_PAGE: advance = {a[ADDR_W-1:5], a[4:0] + 5'd1};
      default:   advance = a + addr_t'(1'b1);
    endcase
  endfunction

  assign byte_done_s = (state_q != ST_IDLE) && sck_rise_s && (bit_cnt_q == 3'd7);
  assign byte_val_s  = {shift_in_q[6:0], si_s};
  assign addr_next_s = advance(addr_q, mode_s);
  assign addr_load_s = addr_t'({addr_hi_q, byte_val_s});
  assign status_s    = {mode_s, 6'b000000};

`ifdef SPI_SRAM_RESP_STATUS_EN
  mode_e mode_q, mode_d;

  always_comb begin
    if (byte_done_s && (state_q == ST_WRSR)) mode_d = decode_mode(byte_val_s[7:6]);
    else                                     mode_d = mode_q;
  end

  always_ff @(posedge clk50_i or negedge rst_n_i) begin
    if (!rst_n_i) mode_q <= mode_e'(STATUS_RST[7:6]);
    else          mode_q <= mode_d;
  end

  assign mode_s = mode_q;
`else
  assign mode_s = MODE_SEQ;
`endif

  always_ff @(posedge clk50_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // A CS rise wins over any byte-driven transition; the completing byte is still
  // committed by the datapath in the same cycle.
  always_comb begin
    state_d = state_q;
    if (cs_rise_s && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: state_d = cs_fall_s ? ST_CMD : ST_IDLE;
        ST_CMD: begin
          if (byte_done_s) begin
            case (byte_val_s)
              OP_READ, OP_WRITE: state_d = ST_ADDR_HI;
`ifdef SPI_SRAM_RESP_STATUS_EN
              OP_RDSR:           state_d = ST_RDSR;
              OP_WRSR:           state_d = ST_WRSR;
`endif
              default:           state_d = ST_IGNORE;
            endcase
          end else begin
            state_d = ST_CMD;
          end
        end
        ST_ADDR_HI: state_d = byte_done_s ? ST_ADDR_LO : ST_ADDR_HI;
        ST_ADDR_LO: begin
          if (byte_done_s) state_d = is_write_q ? ST_WRITE : ST_READ;
          else             state_d = ST_ADDR_LO;
        end
        ST_READ, ST_WRITE: begin
          if (byte_done_s && (mode_s == MODE_BYTE)) state_d = ST_IGNORE;
          else                                      state_d = state_q;
        end
        ST_WRSR:   state_d = byte_done_s ? ST_IGNORE : ST_WRSR;
        ST_RDSR:   state_d = ST_RDSR;
        ST_IGNORE: state_d = ST_IGNORE;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    shift_in_d  = shift_in_q;
    shift_out_d = shift_out_q;
    addr_hi_d   = addr_hi_q;
    addr_d      = addr_q;
    is_write_d  = is_write_q;
    mem_we_s    = 1'b0;
    if ((state_q == ST_IDLE) || (state_d == ST_IDLE)) begin
      bit_cnt_d  = 3'd0;
      shift_in_d = 8'h00;
    end else if (sck_rise_s) begin
      bit_cnt_d  = bit_cnt_q + 3'd1;
      shift_in_d = byte_val_s;
    end else begin
      bit_cnt_d  = bit_cnt_q;
    end
    // Next outgoing byte is loaded on the 8th rise so its MSB is ready for the next fall.
    if (byte_done_s) begin
      case (state_q)
        ST_CMD: begin
          is_write_d  = (byte_val_s == OP_WRITE);
          shift_out_d = status_s;
        end
        ST_ADDR_HI: addr_hi_d = byte_val_s;
        ST_ADDR_LO: begin
          addr_d      = addr_load_s;
          shift_out_d = mem_q[addr_load_s];
        end
        ST_READ: begin
          addr_d      = addr_next_s;
          shift_out_d = mem_q[addr_next_s];
        end
        ST_WRITE: begin
          mem_we_s = 1'b1;
          addr_d   = addr_next_s;
        end
        ST_RDSR: shift_out_d = status_s;
        default: shift_out_d = shift_out_q;
      endcase
    end else if (sck_fall_s && ((state_q == ST_READ) || (state_q == ST_RDSR))) begin
      shift_out_d = {shift_out_q[6:0], 1'b0};
    end else begin
      shift_out_d = shift_out_q;
    end
  end

  always_comb begin
    oe_d = (state_d == ST_READ) || (state_d == ST_RDSR);
    if (!oe_d)           so_d = 1'b0;
    else if (sck_fall_s) so_d = shift_out_q[7];
    else                 so_d = so_q;
  end

  always_ff @(posedge clk50_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      bit_cnt_q   <= 3'd0;
      shift_in_q  <= 8'h00;
      shift_out_q <= 8'h00;
      addr_hi_q   <= 8'h00;
      addr_q      <= '0;
      is_write_q  <= 1'b0;
      so_q        <= 1'b0;
      oe_q        <= 1'b0;
    end else begin
      bit_cnt_q   <= bit_cnt_d;
      shift_in_q  <= shift_in_d;
      shift_out_q <= shift_out_d;
      addr_hi_q   <= addr_hi_d;
      addr_q      <= addr_d;
      is_write_q  <= is_write_d;
      so_q        <= so_d;
      oe_q        <= oe_d;
    end
  end

  // Array contents survive reset.
  always_ff @(posedge clk50_i) begin
    if (mem_we_s) mem_q[addr_q] <= byte_val_s;
  end

  assign mem_so_o    = so_q;
  assign mem_so_oe_o = oe_q;

endmodule

// File: tb/tb_spi_sram_responder.sv
// Scoreboard bench for spi_sram_responder: stimulus queues expected read bytes and
// per-frame output-enable bit counts; a monitor compares what the DUT shifts out.
`timescale 1ns/1ps
module tb_spi_sram_responder;

  logic clk50 = 1'b0;
  logic rst_n = 1'b0;
  logic sck   = 1'b0;
  logic cs    = 1'b1;
  logic si    = 1'b0;
  logic so, oe;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_byte_q [$];
  int         exp_oe_q   [$];

  int         mon_bits = 0;
  int         mon_oe   = 0;
  logic [7:0] mon_sh   = 8'h00;
  logic       sck_prev = 1'b0;
  logic       cs_prev  = 1'b1;

  always #5 clk50 = ~clk50;

  spi_sram_responder #(.ADDR_W(8), .SYNC_STAGES(2)) dut (
    .clk50_i     (clk50),
    .rst_n_i     (rst_n),
    .mem_clk_i   (sck),
    .mem_cs_i    (cs),
    .mem_si_i    (si),
    .mem_so_o    (so),
    .mem_so_oe_o (oe)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: samples just after each clk50 rise, where SPI inputs (driven on the fall) are stable.
  always @(posedge clk50) begin
    #1;
    if (cs && !cs_prev) begin
      if (exp_oe_q.size() == 0) check("frame_oe_unexpected", 32'(mon_oe), 32'hFFFF_FFFF);
      else                      check("frame_oe_bits", 32'(mon_oe), 32'(exp_oe_q.pop_front()));
    end
    if (!cs && cs_prev) begin
      mon_bits = 0;
      mon_oe   = 0;
    end
    if (!rst_n) mon_bits = 0;
    if (sck && !sck_prev && !cs && oe) begin
      mon_oe++;
      mon_sh = {mon_sh[6:0], so};
      mon_bits++;
      if (mon_bits == 8) begin
        mon_bits = 0;
        if (exp_byte_q.size() == 0) check("read_byte_unexpected", {24'h0, mon_sh}, 32'hFFFF_FFFF);
        else                        check("read_byte", {24'h0, mon_sh}, {24'h0, exp_byte_q.pop_front()});
      end
    end
    sck_prev = sck;
    cs_prev  = cs;
  end

  task automatic half();
    repeat (6) @(negedge clk50);
  endtask

  task automatic xfer_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      si = b[7-i];
      half();
      sck = 1'b1;
      half();
      sck = 1'b0;
    end
  endtask

  task automatic xfer(input logic [7:0] b);
    xfer_bits(b, 8);
  endtask

  task automatic cs_lo(input int exp_oe_bits);
    exp_oe_q.push_back(exp_oe_bits);
    @(negedge clk50);
    cs = 1'b0;
    half();
  endtask

  task automatic cs_hi(input int gap);
    half();
    cs = 1'b1;
    repeat (gap) @(negedge clk50);
  endtask

  task automatic hdr(input logic [7:0] op, input logic [15:0] a);
    xfer(op);
    xfer(a[15:8]);
    xfer(a[7:0]);
  endtask

  task automatic wr(input logic [15:0] a, input int n, input logic [31:0] d);
    cs_lo(0);
    hdr(8'h02, a);
    for (int i = 0; i < n; i++) xfer(d[8*(n-1-i) +: 8]);
    cs_hi(8);
  endtask

  task automatic rd(input logic [15:0] a, input int n, input logic [31:0] e);
    for (int i = 0; i < n; i++) exp_byte_q.push_back(e[8*(n-1-i) +: 8]);
    cs_lo(8 * n);
    hdr(8'h03, a);
    for (int i = 0; i < n; i++) xfer(8'h00);
    cs_hi(8);
  endtask

  task automatic wrsr(input logic [7:0] v);
    cs_lo(0);
    xfer(8'h01);
    xfer(v);
    cs_hi(8);
  endtask

  initial begin
    repeat (3) @(negedge clk50);
    check("reset_so", 32'(so), 32'h0);
    check("reset_oe", 32'(oe), 32'h0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk50);

`ifdef SPI_SRAM_RESP_STATUS_EN
    exp_byte_q.push_back(8'h40);
    exp_byte_q.push_back(8'h40);
    cs_lo(16);
    xfer(8'h05); xfer(8'h00); xfer(8'h00);
    cs_hi(8);
    wrsr(8'h80);
    wr(16'h003E, 3, 32'h00_010203);
    rd(16'h003E, 3, 32'h00_010203);
    rd(16'h0020, 1, 32'h03);
    exp_byte_q.push_back(8'h80);
    cs_lo(8);
    xfer(8'h05); xfer(8'h00);
    cs_hi(8);
    wrsr(8'h40);
    wr(16'h0050, 2, 32'h0000_0066);
    wrsr(8'h00);
    wr(16'h0050, 2, 32'h0000_7788);
    rd(16'h0050, 1, 32'h77);
    exp_byte_q.push_back(8'h66);
    cs_lo(8);
    hdr(8'h03, 16'h0051); xfer(8'h00); xfer(8'h00);
    cs_hi(8);
    wrsr(8'hC0);
    exp_byte_q.push_back(8'h40);
    cs_lo(8);
    xfer(8'h05); xfer(8'h00);
    cs_hi(8);
`else
    cs_lo(0);
    xfer(8'h05); xfer(8'h00);
    cs_hi(8);
    wrsr(8'h80);
    wr(16'h003E, 3, 32'h00_010203);
    rd(16'h003E, 3, 32'h00_010203);
    rd(16'h0040, 1, 32'h03);
`endif

    wr(16'h0010, 2, 32'h0000_A55A);
    rd(16'h0010, 2, 32'h0000_A55A);
    rd(16'h0110, 1, 32'hA5);

    wr(16'h00FF, 2, 32'h0000_FFEE);
    rd(16'h00FF, 2, 32'h0000_FFEE);
    rd(16'h0000, 1, 32'hEE);

    wr(16'h0020, 1, 32'h11);
    cs_lo(0);
    hdr(8'h02, 16'h0020);
    xfer_bits(8'hCC, 4);
    cs_hi(4);
    rd(16'h0020, 1, 32'h11);

    cs_lo(0);
    xfer(8'h9F); xfer(8'h00); xfer(8'h00);
    cs_hi(8);
    rd(16'h0010, 1, 32'hA5);

    // Reset mid-read with CS held low: one byte delivered, three bits of the next.
    exp_byte_q.push_back(8'hA5);
    cs_lo(11);
    hdr(8'h03, 16'h0010);
    xfer(8'h00);
    xfer_bits(8'h00, 3);
    rst_n = 1'b0;
    #1;
    check("midreset_so", 32'(so), 32'h0);
    check("midreset_oe", 32'(oe), 32'h0);
    repeat (3) @(negedge clk50);
    rst_n = 1'b1;
    xfer(8'h03); xfer(8'h00); xfer(8'h11); xfer(8'h00);
    cs_hi(8);
    rd(16'h0011, 1, 32'h5A);

    repeat (4) @(negedge clk50);
    check("bytes_left", 32'(exp_byte_q.size()), 32'h0);
    check("frames_left", 32'(exp_oe_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_sram_responder.md
SPI_SRAM_RESPONDER -- requirements
Module: spi_sram_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning log2 of the internal byte array depth (256 bytes).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, meaning the synchronizer depth for mem_clk_i and mem_cs_i.
REQ-003 SHALL have port clk50_i, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n_i, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port mem_clk_i, input, 1 bit: serial clock from the initiator, asynchronous to clk50_i.
REQ-006 SHALL have port mem_cs_i, input, 1 bit: chip select, active low.
REQ-007 SHALL have port mem_si_i, input, 1 bit: serial data in, MSB first (wire mem_dat[0]).
REQ-008 SHALL have port mem_so_o, output, 1 bit: serial data out (wire mem_dat[1]).
REQ-009 SHALL have port mem_so_oe_o, output, 1 bit: output enable for mem_so_o; the enclosing level builds the tristate.

Function
REQ-010 SHALL synchronize mem_clk_i and mem_cs_i through SYNC_STAGES flops, and SHALL derive single-cycle rise/fall strobes from the synchronized clock.
REQ-011 SHALL delay mem_si_i by the same stage count, so that it is sampled coherently on the synchronized SCK rise.
REQ-012 SHALL require mem_clk_i high/low phases >= 4 clk50_i periods; faster SCK is unsupported.
REQ-013 SHALL use SPI mode 0: shift in on each SCK rise, and update mem_so_o within SYNC_STAGES+2 clk50_i cycles after each SCK fall.
REQ-014 SHALL use these FSM states: IDLE, CMD, ADDR_HI, ADDR_LO, READ, WRITE, RDSR, WRSR, IGNORE.
REQ-015 IDLE->CMD on synchronized CS fall; the 8-bit counter is cleared.
REQ-016 CMD decodes after 8 bits: 0x03->ADDR_HI (read); 0x02->ADDR_HI (write); 0x05->RDSR; 0x01->WRSR; any other opcode->IGNORE.
REQ-017 ADDR_HI->ADDR_LO after 8 bits; ADDR_LO->READ or WRITE after 8 bits; the address is 16 bits, and only bits [ADDR_W-1:0] are kept.
REQ-018 READ: the first data bit (bit 7 of mem[addr]) SHALL be presented after the SCK fall that follows the last address bit.
REQ-019 Each READ byte SHALL then shift MSB first; addr advances per mode after each byte.
REQ-020 WRITE: mem[addr] SHALL be written one clk50_i cycle after the 8th bit's SCK rise; addr then advances per mode.
REQ-021 Address advance, sequential mode: addr+1, wrapping from 2^ADDR_W-1 to 0.
REQ-022 Address advance, page mode: the low 5 bits increment with wrap inside a 32-byte page.
REQ-023 Address advance, byte mode: no advance; further bytes go to IGNORE (write discarded, read returns 0).
REQ-024 mem_so_oe_o SHALL be 1 only in READ and RDSR while CS is low; otherwise mem_so_oe_o=0 and mem_so_o=0.
REQ-025 A CS rise in any state SHALL return the FSM to IDLE within SYNC_STAGES+1 cycles; a partial write byte is discarded and completed bytes persist.
REQ-026 If a CS rise and the 8th SCK rise land in the same synchronized cycle, the byte completes first.
REQ-027 IGNORE holds until CS rises.

Reset
REQ-028 While rst_n_i=0: FSM in IDLE, counters and shift registers 0, mem_so_o=0, mem_so_oe_o=0, status=0x40 (sequential).
REQ-029 Reset SHALL NOT clear array contents.
REQ-030 A reset asserted mid-transfer SHALL abort it; after release, the FSM waits for a fresh CS fall (a CS already low is ignored until it rises).

Configuration
REQ-031 SHALL use macro SPI_SRAM_RESP_STATUS_EN.
REQ-032 With SPI_SRAM_RESP_STATUS_EN defined: RDSR shifts out status {mode[1:0],6'b0}, repeating each byte.
REQ-033 With SPI_SRAM_RESP_STATUS_EN defined: WRSR loads mode from bits 7:6, where 00=byte, 01=sequential, 10=page and 11 is treated as sequential.
REQ-034 Without SPI_SRAM_RESP_STATUS_EN: 0x05/0x01 go to IGNORE, mode is fixed sequential, and no status register is built.

Structure
REQ-035 A shared package spi_sram_pkg SHALL hold the opcode constants, the FSM state encoding, the mode encodings and the status reset value 0x40.
REQ-036 One sub-module spi_sram_sync SHALL provide the synchronizer chain plus SCK rise/fall and CS fall/rise strobes; the array is inferred inside the top module.

Verification
REQ-037 Write 0x02, addr 0x0010, data 0xA5,0x5A, CS high; then read 0x03, addr 0x0010, 2 bytes -> mem_so_o returns 0xA5,0x5A and mem_so_oe_o=1 only during data.
REQ-038 Sequential wrap: write 0xFF,0xEE at addr 0x00FF; read addr 0x00FF for 2 bytes -> 0xFF then 0xEE, with mem[0x00]=0xEE.
REQ-039 CS raised after 4 bits of a write to 0x0020 (old value 0x11) -> mem[0x20] stays 0x11, and the FSM is IDLE within 3 cycles.
REQ-040 Opcode 0x9F -> IGNORE, mem_so_oe_o stays 0 for the whole frame, and the next frame decodes normally.
REQ-041 With SPI_SRAM_RESP_STATUS_EN: RDSR after reset -> 0x40; WRSR 0x80 then write 3 bytes at 0x003E -> 0x3E, 0x3F, 0x20 written; RDSR -> 0x80.
REQ-042 rst_n_i pulsed low mid-read with CS held low -> outputs 0 immediately; no response until CS rises and falls again.
